// File: rtl/clause_ctrl.sv
// Sequencer for one Tsetlin clause: latches a request, drives the shared TA-bank
// controls, ANDs the TA results and, in training, feeds the clause result back.
module clause_ctrl #(
  parameter int          N_TA      = 8,
  parameter int          FB_CYCLES = 3,
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            train,
  input  logic            feedback_type,
  input  logic [N_TA-1:0] literals,
  input  logic [N_TA-1:0] ta_ready,
  input  logic [N_TA-1:0] ta_done,
  input  logic [N_TA-1:0] ta_result,
  output logic            ta_enable,
  output logic            ta_training_sel,
  output logic [N_TA-1:0] ta_literal,
  output logic            ta_type_feedback,
  output logic            ta_clause_result,
  output logic [N_TA-1:0] ta_rand,
  output logic            busy,
  output logic            valid,
  output logic            clause_out,
  output logic            error
);

  localparam int MAXC = (TIMEOUT > FB_CYCLES + 2) ? TIMEOUT : FB_CYCLES + 2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, RUN, FINISH} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [15:0]   lfsr;
  logic          train_q, clause_q;
  logic          all_rdy, all_done, all_res;
  logic          cnt_to, cnt_fb, cnt_eval;
  logic          accept, fin_set, fin_err, fin_val;

  assign all_rdy  = &ta_ready;
  assign all_done = &ta_done;
  assign all_res  = &ta_result;
  assign cnt_to   = (cnt == CW'(TIMEOUT - 1));
  assign cnt_fb   = (cnt == CW'(FB_CYCLES + 1));
  assign cnt_eval = (cnt == CW'(1));

  assign busy    = (state != IDLE);
  assign valid   = (state == FINISH);
  assign ta_rand = lfsr[N_TA-1:0];

  // Enable and feedback lines decode straight from state so an async reset
  // drops them without waiting for a clock.
  always_comb begin
    state_nx         = state;
    accept           = 1'b0;
    fin_set          = 1'b0;
    fin_err          = 1'b0;
    fin_val          = 1'b0;
    ta_enable        = 1'b0;
    ta_training_sel  = 1'b0;
    ta_clause_result = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (all_rdy) state_nx = RUN;
        else if (cnt_to) begin
          state_nx = FINISH;
          fin_set  = 1'b1;
          fin_err  = 1'b1;
        end
      end
      RUN: begin
        ta_enable       = 1'b1;
        ta_training_sel = train_q;
        if (train_q) begin
          // cnt 0: TAs evaluate; cnt 1: result is live; later: held copy.
          if (cnt_eval)         ta_clause_result = all_res;
          else if (cnt != '0)   ta_clause_result = clause_q;
          if (cnt_fb) begin
            state_nx = FINISH;
            fin_set  = 1'b1;
            fin_val  = clause_q;
          end
        end else if (all_done) begin
          state_nx = FINISH;
          fin_set  = 1'b1;
          fin_val  = all_res;
        end else if (cnt_to) begin
          state_nx = FINISH;
          fin_set  = 1'b1;
          fin_err  = 1'b1;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      lfsr             <= LFSR_SEED;
      train_q          <= 1'b0;
      clause_q         <= 1'b0;
      ta_literal       <= '0;
      ta_type_feedback <= 1'b0;
      clause_out       <= 1'b0;
      error            <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      // cnt restarts on every state entry and only runs in the waiting states
      if ((state == WAIT_RDY || state == RUN) && state_nx == state) cnt <= cnt + CW'(1);
      else                                                          cnt <= '0;
      if (accept) begin
        ta_literal       <= literals;
        train_q          <= train;
        ta_type_feedback <= feedback_type;
        error            <= 1'b0;
      end
      if (state == RUN && train_q && cnt_eval) clause_q <= all_res;
      if (fin_set) begin
        clause_out <= fin_val;
        error      <= fin_err;
      end
    end
  end

endmodule

// File: tb/tb_clause_ctrl.sv
// Randomized bench for clause_ctrl: a TA-bank stand-in drives ready/done/result,
// and each run is scored against run-level expectations derived from the timing rules.
module tb_clause_ctrl;
  localparam int N  = 8;
  localparam int FB = 3;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start = 1'b0, train = 1'b0, feedback_type = 1'b0;
  logic [N-1:0] literals = '0, ta_ready = '0, ta_done = '0, ta_result = '0;
  logic         ta_enable, ta_training_sel, ta_type_feedback, ta_clause_result;
  logic         busy, valid, clause_out, error;
  logic [N-1:0] ta_literal, ta_rand;

  int           vecs = 0, errs = 0;
  int           cyc = 0;
  logic [15:0]  seq [0:8191];

  always #5 clk = ~clk;

  clause_ctrl #(.N_TA(N), .FB_CYCLES(FB), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .train(train), .feedback_type(feedback_type),
    .literals(literals), .ta_ready(ta_ready), .ta_done(ta_done), .ta_result(ta_result),
    .ta_enable(ta_enable), .ta_training_sel(ta_training_sel), .ta_literal(ta_literal),
    .ta_type_feedback(ta_type_feedback), .ta_clause_result(ta_clause_result),
    .ta_rand(ta_rand), .busy(busy), .valid(valid), .clause_out(clause_out), .error(error)
  );

  // clocks since reset release; indexes the precomputed LFSR sequence
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] notall();
    logic [7:0] v;
    v = 8'($urandom);
    v[$urandom_range(7, 0)] = 1'b0;
    return v;
  endfunction

  task automatic chk_rand();
    logic [15:0] s;
    s = seq[cyc % 8192];
    chk("ta_rand", ta_rand, s[7:0]);
  endtask

  // rdy_d: WAIT_RDY cycles before ready goes high (>=TO means never)
  // done_d: enabled cycles before done goes high (inference only)
  task automatic run(input bit tr, input bit fb, input logic [7:0] lits, input int rdy_d,
                     input int done_d, input logic [7:0] res, input bit poke);
    int   w, en_exp, vk_exp, en, vk, vcnt, cr_bad, sel_bad;
    bit   err_exp, co_exp;
    logic exp_cr;
    en = 0; vk = 0; vcnt = 0; cr_bad = 0; sel_bad = 0;
    w = (rdy_d >= TO) ? TO : rdy_d + 1;
    if (rdy_d >= TO)         begin en_exp = 0;        err_exp = 1; co_exp = 0;    end
    else if (tr)             begin en_exp = 2 + FB;   err_exp = 0; co_exp = &res; end
    else if (done_d + 1 <= TO) begin en_exp = done_d + 1; err_exp = 0; co_exp = &res; end
    else                     begin en_exp = TO;       err_exp = 1; co_exp = 0;    end
    vk_exp = w + en_exp + 1;

    @(negedge clk);
    start = 1'b1; train = tr; feedback_type = fb; literals = lits;
    ta_ready = notall(); ta_done = notall(); ta_result = notall();
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start         = poke && (k == 2);
      literals      = (poke && k == 2) ? ~lits : 8'($urandom);
      train         = 1'($urandom);
      feedback_type = 1'($urandom);
      if (ta_enable) en++;
      ta_ready  = (k > rdy_d) ? '1 : notall();
      ta_done   = (ta_enable && en > done_d) ? '1 : notall();
      ta_result = (tr && en != 2) ? ~res : res;
      #1;
      exp_cr = tr && ta_enable && (en >= 2) && (&res);
      if (ta_clause_result !== exp_cr) cr_bad++;
      if (ta_training_sel !== (ta_enable & tr)) sel_bad++;
      chk_rand();
      if (valid) begin
        vcnt++;
        if (vk == 0) begin
          vk = k;
          chk("clause_out", clause_out, co_exp);
          chk("error", error, err_exp);
          chk("ta_literal", ta_literal, lits);
          chk("ta_type_feedback", ta_type_feedback, fb);
        end
      end
      if (vk != 0 && k == vk + 1) begin
        chk("busy_after_finish", busy, 0);
        break;
      end
    end
    chk("valid_cycle", vk, vk_exp);
    chk("enable_cycles", en, en_exp);
    chk("valid_pulses", vcnt, 1);
    chk("clause_result_bad_cycles", cr_bad, 0);
    chk("training_sel_bad_cycles", sel_bad, 0);
  endtask

  initial begin
    bit          tr, fb;
    int          rd, dd, en;
    logic [7:0]  rs;
    seq[0] = 16'hACE1;
    for (int i = 1; i < 8192; i++)
      seq[i] = seq[i-1][0] ? ((seq[i-1] >> 1) ^ 16'hB400) : (seq[i-1] >> 1);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enable", ta_enable, 0);
    chk("rst_training_sel", ta_training_sel, 0);
    chk("rst_literal", ta_literal, 0);
    chk("rst_clause_result", ta_clause_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_clause_out", clause_out, 0);
    chk("rst_error", error, 0);
    chk("rst_rand", ta_rand, 8'hE1);
    rst = 1'b0;
    #1 chk("lfsr_0", ta_rand, 8'hE1);
    @(negedge clk); #1 chk("lfsr_1", ta_rand, 8'h70);
    @(negedge clk); #1 chk("lfsr_2", ta_rand, 8'h38);

    run(0, 0, 8'hFF, 0, 2, 8'hFF, 0);   // inference, all ones
    run(0, 1, 8'hFF, 1, 2, 8'hF7, 0);   // inference, one zero bit
    run(1, 1, 8'h3C, 0, 0, 8'hFF, 0);   // training
    run(1, 0, 8'h5A, 0, 0, 8'hEF, 0);   // training, zero clause
    run(0, 0, 8'h55, 99, 0, 8'hFF, 0);  // ready timeout
    run(0, 1, 8'h12, 0, 20, 8'hFF, 0);  // done timeout
    run(0, 0, 8'h34, 0, 14, 8'hFF, 0);  // done on the timeout cycle
    run(0, 0, 8'h66, 14, 1, 8'hFF, 0);  // ready on the timeout cycle
    run(1, 0, 8'h81, 2, 0, 8'hFF, 1);   // start while busy is ignored

    // reset during training RUN cycle 3
    @(negedge clk);
    start = 1'b1; train = 1'b1; feedback_type = 1'b1; literals = 8'hA5; ta_ready = '1;
    ta_result = '1;
    @(negedge clk);
    start = 1'b0;
    en = 0;
    for (int k = 0; k < 10; k++) begin
      if (ta_enable) en++;
      if (en == 3) break;
      @(negedge clk);
    end
    chk("rst_setup_enabled", en, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_enable", ta_enable, 0);
    chk("midrst_training_sel", ta_training_sel, 0);
    chk("midrst_clause_result", ta_clause_result, 0);
    chk("midrst_literal", ta_literal, 0);
    chk("midrst_type_fb", ta_type_feedback, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rand", ta_rand, 8'hE1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_lfsr_0", ta_rand, 8'hE1);
    @(negedge clk); #1 chk("midrst_lfsr_1", ta_rand, 8'h70);
    @(negedge clk); #1 chk("midrst_lfsr_2", ta_rand, 8'h38);

    for (int i = 0; i < 20; i++) begin
      tr = 1'($urandom);
      fb = 1'($urandom);
      rd = ($urandom_range(9, 0) == 0) ? 16 : $urandom_range(4, 0);
      dd = ($urandom_range(9, 0) == 0) ? 20 : $urandom_range(5, 0);
      rs = $urandom_range(1, 0) ? 8'hFF : notall();
      run(tr, fb, 8'($urandom), rd, dd, rs, $urandom_range(3, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
